// File: rtl/bp_me_wb_if.sv
// Shared Bedrock definitions plus the bundle of Bedrock and Wishbone signals seen by bp_me_wb_master.
// Header layout, LSB first: msg_type[3:0], addr[paddr-1:0], size[2:0], payload.
package bp_me_wb_pkg;
  typedef enum logic [1:0] {e_bp_default_cfg, e_bp_small_cfg} bp_params_e;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3
  } bedrock_msg_e;

  function automatic int cfg_paddr_width(input bp_params_e c);
    return (c == e_bp_small_cfg) ? 32 : 40;
  endfunction

  function automatic int cfg_did_width(input bp_params_e c);
    return (c == e_bp_small_cfg) ? 1 : 3;
  endfunction

  function automatic int cfg_lce_id_width(input bp_params_e c);
    return (c == e_bp_small_cfg) ? 2 : 4;
  endfunction

  function automatic int cfg_lce_assoc(input bp_params_e c);
    return (c == e_bp_small_cfg) ? 4 : 8;
  endfunction

  // Payload carries the requester identity, returned untouched in the response.
  function automatic int cfg_payload_width(input bp_params_e c);
    return cfg_did_width(c) + cfg_lce_id_width(c) + $clog2(cfg_lce_assoc(c));
  endfunction
endpackage

interface bp_me_wb_if #(
  parameter int paddr_width_p   = 40,
  parameter int payload_width_p = 10,
  parameter int data_width_p    = 64
);
  localparam int header_width_lp = 7 + paddr_width_p + payload_width_p;
  localparam int sel_width_lp    = data_width_p / 8;
  localparam int adr_width_lp    = paddr_width_p - $clog2(sel_width_lp);

  // Both Bedrock channels are ready-and: a beat transfers on a rising clock
  // edge where v and ready_and are both 1; v may not depend on ready_and.
  logic [header_width_lp-1:0] mem_fwd_header_i;
  logic [data_width_p-1:0]    mem_fwd_data_i;
  logic                       mem_fwd_v_i;
  logic                       mem_fwd_ready_and_o;
  logic                       mem_fwd_last_i;
  logic [header_width_lp-1:0] mem_rev_header_o;
  logic [data_width_p-1:0]    mem_rev_data_o;
  logic                       mem_rev_v_o;
  logic                       mem_rev_ready_and_i;
  logic                       mem_rev_last_o;
  logic [adr_width_lp-1:0]    adr_o;
  logic [data_width_p-1:0]    dat_o;
  logic                       cyc_o;
  logic                       stb_o;
  logic                       we_o;
  logic [sel_width_lp-1:0]    sel_o;
  logic [data_width_p-1:0]    dat_i;
  logic                       ack_i;
  logic [1:0]                 dbg_state_o;

  modport master (
    input  mem_fwd_header_i, mem_fwd_data_i, mem_fwd_v_i, mem_fwd_last_i,
           mem_rev_ready_and_i, dat_i, ack_i,
    output mem_fwd_ready_and_o, mem_rev_header_o, mem_rev_data_o, mem_rev_v_o,
           mem_rev_last_o, adr_o, dat_o, cyc_o, stb_o, we_o, sel_o, dbg_state_o
  );

  modport slave (
    output mem_fwd_header_i, mem_fwd_data_i, mem_fwd_v_i, mem_fwd_last_i,
           mem_rev_ready_and_i, dat_i, ack_i,
    input  mem_fwd_ready_and_o, mem_rev_header_o, mem_rev_data_o, mem_rev_v_o,
           mem_rev_last_o, adr_o, dat_o, cyc_o, stb_o, we_o, sel_o, dbg_state_o
  );
endinterface

// File: rtl/bp_me_wb_master.sv
// Single-beat Bedrock memory command to Wishbone B4 classic master bridge.
// Optional bus watchdog enabled by defining BP_ME_WB_MASTER_TIMEOUT_EN.
module bp_me_wb_master
  import bp_me_wb_pkg::*;
#(
  parameter bp_params_e bp_params_p      = e_bp_default_cfg,
  parameter int         data_width_p     = 64,
  parameter int         timeout_cycles_p = 1024
) (
  input logic         clk_i,
  input logic         reset_n_i,
  bp_me_wb_if.master  bus_io
);
  localparam int paddr_width_lp = cfg_paddr_width(bp_params_p);
  localparam int hdr_width_lp   = 7 + paddr_width_lp + cfg_payload_width(bp_params_p);
  localparam int bytes_lp       = data_width_p / 8;
  localparam int lg_bytes_lp    = $clog2(bytes_lp);
  localparam int off_w_lp       = (lg_bytes_lp > 0) ? lg_bytes_lp : 1;
  localparam int timer_w_lp     = $clog2(timeout_cycles_p + 1);

  typedef enum logic [1:0] {e_ready, e_bus, e_resp} state_e;

  state_e                    state_q;
  logic [hdr_width_lp-1:0]   header_q;
  logic [data_width_p-1:0]   dat_q;
  logic [data_width_p-1:0]   rev_data_q;
  logic [paddr_width_lp-lg_bytes_lp-1:0] adr_q;
  logic [bytes_lp-1:0]       sel_q;
  logic                      cyc_q, stb_q, we_q, rev_v_q;
  logic                      timeout_hit;

  logic [3:0]                fwd_msg;
  logic [paddr_width_lp-1:0] fwd_addr, q_addr;
  logic [2:0]                fwd_size, q_size;
  logic [off_w_lp-1:0]       fwd_mask, fwd_off, q_mask, q_off, lane_idx;
  logic [bytes_lp-1:0]       sel_d;
  logic [data_width_p-1:0]   rd_data_d;

  // Lane mask: low bits of the byte offset that fall inside one access.
  // Sizes at or above the bus width saturate to the full bus.
  function automatic logic [off_w_lp-1:0] size_mask(input logic [2:0] sz);
    logic [off_w_lp-1:0] m;
    m = '0;
    for (int i = 0; i < lg_bytes_lp; i++) if (i < int'(sz)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [off_w_lp-1:0] byte_off(input logic [paddr_width_lp-1:0] a);
    return (lg_bytes_lp == 0) ? '0 : a[off_w_lp-1:0];
  endfunction

  assign fwd_msg  = bus_io.mem_fwd_header_i[3:0];
  assign fwd_addr = bus_io.mem_fwd_header_i[paddr_width_lp+3:4];
  assign fwd_size = bus_io.mem_fwd_header_i[paddr_width_lp+6:paddr_width_lp+4];
  assign q_addr   = header_q[paddr_width_lp+3:4];
  assign q_size   = header_q[paddr_width_lp+6:paddr_width_lp+4];
  assign fwd_mask = size_mask(fwd_size);
  assign fwd_off  = byte_off(fwd_addr);
  assign q_mask   = size_mask(q_size);
  assign q_off    = byte_off(q_addr);

  always_comb begin
    sel_d = '0;
    for (int i = 0; i < bytes_lp; i++)
      sel_d[i] = ((off_w_lp'(i) & ~fwd_mask) == (fwd_off & ~fwd_mask));
  end

  // Pick the addressed lane of the bus data and replicate it across the word.
  always_comb begin
    rd_data_d = '0;
    lane_idx  = '0;
    for (int i = 0; i < bytes_lp; i++) begin
      lane_idx = (q_off & ~q_mask) | (off_w_lp'(i) & q_mask);
      rd_data_d[8*i +: 8] = bus_io.dat_i[8*lane_idx +: 8];
    end
  end

`ifdef BP_ME_WB_MASTER_TIMEOUT_EN
  logic [timer_w_lp-1:0] timer_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)              timer_q <= '0;
    else if (state_q != e_bus)   timer_q <= '0;
    else                         timer_q <= timer_q + 1'b1;
  end

  assign timeout_hit = (state_q == e_bus) && (timer_q == timer_w_lp'(timeout_cycles_p - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= e_ready;
      header_q   <= '0;
      dat_q      <= '0;
      rev_data_q <= '0;
      adr_q      <= '0;
      sel_q      <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      rev_v_q    <= 1'b0;
    end else begin
      case (state_q)
        e_ready: if (bus_io.mem_fwd_v_i) begin
          header_q <= bus_io.mem_fwd_header_i;
          dat_q    <= bus_io.mem_fwd_data_i;
          adr_q    <= fwd_addr[paddr_width_lp-1:lg_bytes_lp];
          sel_q    <= sel_d;
          we_q     <= (fwd_msg == e_bedrock_mem_uc_wr);
          cyc_q    <= 1'b1;
          stb_q    <= 1'b1;
          state_q  <= e_bus;
        end
        e_bus: if (bus_io.ack_i || timeout_hit) begin
          rev_data_q <= (!bus_io.ack_i) ? '1 : (we_q ? '0 : rd_data_d);
          rev_v_q    <= 1'b1;
          cyc_q      <= 1'b0;
          stb_q      <= 1'b0;
          we_q       <= 1'b0;
          sel_q      <= '0;
          adr_q      <= '0;
          dat_q      <= '0;
          state_q    <= e_resp;
        end
        e_resp: if (bus_io.mem_rev_ready_and_i) begin
          rev_v_q <= 1'b0;
          state_q <= e_ready;
        end
        default: state_q <= e_ready;
      endcase
    end
  end

  logic unused_last;
  assign unused_last = bus_io.mem_fwd_last_i;

  assign bus_io.mem_fwd_ready_and_o = (state_q == e_ready) && reset_n_i;
  assign bus_io.mem_rev_header_o    = header_q;
  assign bus_io.mem_rev_data_o      = rev_data_q;
  assign bus_io.mem_rev_v_o         = rev_v_q;
  assign bus_io.mem_rev_last_o      = 1'b1;
  assign bus_io.adr_o               = adr_q;
  assign bus_io.dat_o               = dat_q;
  assign bus_io.cyc_o               = cyc_q;
  assign bus_io.stb_o               = stb_q;
  assign bus_io.we_o                = we_q;
  assign bus_io.sel_o               = sel_q;
  assign bus_io.dbg_state_o         = state_q;
endmodule

// File: doc/bp_me_wb_master.md
BP_ME_WB_MASTER -- requirements
Module: bp_me_wb_master

Interface
REQ-001 SHALL have parameter bp_params_p, default e_bp_default_cfg, BP configuration supplying paddr_width_p, did_width_p, lce_id_width_p and lce_assoc_p.
REQ-002 SHALL have parameter data_width_p, default 64, Bedrock and WB data width; legal values 8/16/32/64.
REQ-003 SHALL have parameter timeout_cycles_p, default 1024, watchdog limit; used only with BP_ME_WB_MASTER_TIMEOUT_EN.
REQ-004 SHALL use one clock and an asynchronous active-low reset; ports clk_i and reset_n_i.
REQ-005 clk_i  in  1  clock.
REQ-006 reset_n_i  in  1  async active-low reset.
REQ-007 mem_fwd_header_i  in  mem_fwd_header_width_lp  Bedrock command header.
REQ-008 mem_fwd_data_i  in  data_width_p  write data, replicated below bus width.
REQ-009 mem_fwd_v_i / mem_fwd_ready_and_o / mem_fwd_last_i  in/out/in  1 each  ready-and command handshake; last ignored (single beat).
REQ-010 mem_rev_header_o  out  mem_rev_header_width_lp  response header.
REQ-011 mem_rev_data_o  out  data_width_p  response data.
REQ-012 mem_rev_v_o / mem_rev_ready_and_i / mem_rev_last_o  out/in/out  1 each  ready-and response handshake; last tied 1.
REQ-013 adr_o  out  paddr_width_p-log2(data_width_p/8)  WB word address.
REQ-014 dat_o  out  data_width_p  WB write data.
REQ-015 cyc_o, stb_o, we_o  out  1 each  WB B4 classic cycle/strobe/write.
REQ-016 sel_o  out  data_width_p/8  WB byte selects.
REQ-017 dat_i, ack_i  in  data_width_p, 1  WB read data and acknowledge.

Function
REQ-018 SHALL implement FSM states e_ready, e_bus, e_resp.
REQ-019 e_ready: mem_fwd_ready_and_o=1, all WB outputs 0; on mem_fwd_v_i, register header and data, go e_bus next cycle.
REQ-020 e_bus: cyc_o=stb_o=1; adr_o=addr[paddr-1:log2(bytes)]; we_o=1 iff msg_type==e_bedrock_mem_uc_wr; dat_o=registered data; mem_fwd_ready_and_o=0.
REQ-021 sel_o SHALL be ((1<<2^size)-1) shifted left by addr low bits masked to size alignment; size > bus width clamps to full-width sel (all ones).
REQ-022 On ack_i in e_bus: cyc_o/stb_o drop next cycle, dat_i registered, go e_resp; minimum command-to-response latency 2 cycles.
REQ-023 e_resp: mem_rev_v_o=1, header = registered fwd header (msg_type, addr, size, payload unchanged); on mem_rev_ready_and_i go e_ready.
REQ-024 Read response data SHALL be the addressed size-byte lane of captured dat_i, replicated across data_width_p; write response data SHALL be 0.
REQ-025 ack_i outside e_bus SHALL be ignored; mem_rev backpressure holds e_resp with stable outputs.
REQ-026 At most one transaction outstanding; no new command accepted until response handshake completes.

Reset
REQ-027 While reset_n_i=0: state e_ready, cyc_o=stb_o=we_o=0, sel_o=0, adr_o=0, dat_o=0, mem_rev_v_o=0, registered header/data 0; mem_fwd_ready_and_o forced 0 during reset.
REQ-028 Reset mid-transaction SHALL abandon it immediately (cyc_o drops asynchronously); no response is issued.

Configuration
REQ-029 Macro BP_ME_WB_MASTER_TIMEOUT_EN defined: counter clears on e_bus entry, increments each e_bus cycle; reaching timeout_cycles_p without ack_i drops cyc_o/stb_o and enters e_resp with data all-ones.
REQ-030 Macro undefined: no counter; e_bus waits for ack_i indefinitely.

Verification
REQ-031 uc_rd size 8, addr 0x8000_0008; ack_i after 3 cycles with dat_i=0x1122334455667788 -> adr_o=0x1000_0001, sel_o=0xFF, we_o=0; response data 0x1122334455667788.
REQ-032 uc_wr size 1, addr 0x...0003, data 0xABAB..AB -> sel_o=0x08, we_o=1, dat_o=0xABAB..AB; write response data 0.
REQ-033 uc_rd size 2, addr 0x...0006; dat_i=0xBEEF000000000000 -> sel_o=0xC0; response data 0xBEEFBEEFBEEFBEEF.
REQ-034 Response with mem_rev_ready_and_i low 5 cycles -> mem_rev_v_o and data stable; mem_fwd_ready_and_o=0 throughout.
REQ-035 reset_n_i low during e_bus -> cyc_o=0 same cycle; after release, no mem_rev_v_o; next command processed normally.
REQ-036 TIMEOUT_EN, timeout_cycles_p=16, no ack_i -> cyc_o drops after 16 bus cycles; response data 0xFFFFFFFFFFFFFFFF.
